rf_wb_queue: RTL and testbench

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue_pkg.sv | 18 +
 rtl/rf_wb_queue_if.sv | 55 +++++
 rtl/rf_wb_queue_wb_fifo.sv | 54 +++++
 rtl/rf_wb_queue.sv | 91 +++++++++
 tb/tb_rf_wb_queue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared types for the register-file write-back queue.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package rf_wb_queue_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 4;
  localparam int REG_IDX_W  = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One pending register-file write at the default data width.
  typedef struct packed {
    reg_idx_t                rd;
    logic [DATA_W_DEF-1:0]   data;
  } entry_t;

endpackage

// File: rtl/rf_wb_queue_if.sv
// Handshake and write-port bundle between result producers, decode and the queue.
// Latency: n/a (wiring only).
// Backpressure: ready/valid on the two sources, i_wb_stall on the write port.
interface rf_wb_queue_if #(
  parameter int DATA_W = rf_wb_queue_pkg::DATA_W_DEF,
  parameter int DEPTH  = rf_wb_queue_pkg::DEPTH_DEF
);
  import rf_wb_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic              i_ld_valid;
  logic              o_ld_ready;
  reg_idx_t          i_ld_rd;
  logic [DATA_W-1:0] i_ld_data;

  logic              i_alu_valid;
  logic              o_alu_ready;
  reg_idx_t          i_alu_rd;
  logic [DATA_W-1:0] i_alu_data;

  logic              i_wb_stall;
  logic              o_RegWrite;
  reg_idx_t          o_WriteReg;
  logic [DATA_W-1:0] o_WriteData;

  reg_idx_t          i_query_rd1;
  reg_idx_t          i_query_rd2;
  logic              o_pend1;
  logic              o_pend2;

  logic [CW-1:0]     o_count;
  logic              o_empty;

  // Queue side.
  modport slave (
    input  i_ld_valid, i_ld_rd, i_ld_data,
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_wb_stall, i_query_rd1, i_query_rd2,
    output o_ld_ready, o_alu_ready,
    output o_RegWrite, o_WriteReg, o_WriteData,
    output o_pend1, o_pend2, o_count, o_empty
  );

  // Producer / decode / register-file side.
  modport master (
    output i_ld_valid, i_ld_rd, i_ld_data,
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_wb_stall, i_query_rd1, i_query_rd2,
    input  o_ld_ready, o_alu_ready,
    input  o_RegWrite, o_WriteReg, o_WriteData,
    input  o_pend1, o_pend2, o_count, o_empty
  );

endinterface

// File: rtl/rf_wb_queue_wb_fifo.sv
// Generic synchronous FIFO; exposes its storage so the owner can scan valid entries.
// Latency: a push is visible at the head from the cycle after the push edge.
// Backpressure: none internally; the owner must not push when full without popping.
module wb_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [W-1:0]              i_push_dat,
  input  logic                      i_pop,
  output logic [W-1:0]              o_head_dat,
  output logic [DEPTH-1:0][W-1:0]   o_mem,
  output logic [PW-1:0]             o_rd_ptr,
  output logic [CW-1:0]             o_count
);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_mem      = r_mem;
  assign o_rd_ptr   = r_rd_ptr;
  assign o_count    = r_count;

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue: arbitrates load/ALU results into a FIFO that drains into the register file.
// Latency: an entry enqueued at edge N drives the write port in cycle N+1 (no bypass).
// Backpressure: readies drop when full and not draining; i_wb_stall freezes the head.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rf_wb_queue_if.slave   bus
);

  localparam int RW = REG_IDX_W;
  localparam int EW = RW + DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      w_empty;
  logic                      w_deq;
  logic                      w_ld_ready;
  logic                      w_alu_ready;
  logic                      w_ld_fire;
  logic                      w_alu_fire;
  logic                      w_push;
  logic [EW-1:0]             w_push_dat;
  logic [EW-1:0]             w_head_dat;
  logic [DEPTH-1:0][EW-1:0]  w_mem;
  logic [PW-1:0]             w_rd_ptr;
  logic [CW-1:0]             w_count;
  logic [DEPTH-1:0]          w_vld;
  logic [DEPTH-1:0]          w_hit1;
  logic [DEPTH-1:0]          w_hit2;

  assign w_empty = (w_count == '0);
  // The head retires whenever one exists and the register file can take it.
  assign w_deq   = !w_empty && !bus.i_wb_stall;

  // A slot is available if not full, or if the head leaves on the same edge.
  // Readies are forced low while reset is held.
  assign w_ld_ready  = i_rst_n && ((w_count < CW'(DEPTH)) || w_deq);
  assign w_alu_ready = w_ld_ready && !bus.i_ld_valid;

  assign w_ld_fire  = bus.i_ld_valid  && w_ld_ready;
  assign w_alu_fire = bus.i_alu_valid && w_alu_ready;

  // Writes to x0 complete the handshake but are dropped here.
  assign w_push     = (w_ld_fire  && (bus.i_ld_rd  != '0)) ||
                      (w_alu_fire && (bus.i_alu_rd != '0));
  assign w_push_dat = w_ld_fire ? {bus.i_ld_rd,  bus.i_ld_data}
                                : {bus.i_alu_rd, bus.i_alu_data};

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_deq),
    .o_head_dat (w_head_dat),
    .o_mem      (w_mem),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (w_count)
  );

  // Pending-write match: slot g is live if its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] w_off;
    assign w_off     = PW'(g) - w_rd_ptr;
    assign w_vld[g]  = ({1'b0, w_off} < w_count);
    assign w_hit1[g] = w_vld[g] && (w_mem[g][EW-1 -: RW] == bus.i_query_rd1);
    assign w_hit2[g] = w_vld[g] && (w_mem[g][EW-1 -: RW] == bus.i_query_rd2);
  end

  assign bus.o_pend1 = (bus.i_query_rd1 != '0) && (|w_hit1);
  assign bus.o_pend2 = (bus.i_query_rd2 != '0) && (|w_hit2);

  // Write port shows zeros whenever there is nothing to retire (including reset).
  assign bus.o_RegWrite  = w_deq;
  assign bus.o_WriteReg  = w_empty ? '0 : w_head_dat[EW-1 -: RW];
  assign bus.o_WriteData = w_empty ? '0 : w_head_dat[DATA_W-1:0];

  assign bus.o_ld_ready  = w_ld_ready;
  assign bus.o_alu_ready = w_alu_ready;
  assign bus.o_count     = w_count;
  assign bus.o_empty     = w_empty;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios plus randomized traffic vs a queue model.
// Latency: inputs change on the falling edge, outputs are checked 1-3 time units later.
// Backpressure: random i_wb_stall and source valids exercise full/stalled corners.
module tb_rf_wb_queue;
  import rf_wb_queue_pkg::*;

  localparam int DW = 64;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_queue_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  rf_wb_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the list of writes still owed to the register file, oldest first.
  entry_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle();
    bus.i_ld_valid  = 1'b0;
    bus.i_alu_valid = 1'b0;
    bus.i_ld_rd     = '0;
    bus.i_alu_rd    = '0;
    bus.i_ld_data   = '0;
    bus.i_alu_data  = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    bus.i_alu_valid = 1'b1;
    bus.i_alu_rd    = rd;
    bus.i_alu_data  = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [63:0] d);
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = rd;
    bus.i_ld_data  = d;
  endtask

  // Check every output against the model, then apply this cycle's transfers to the model.
  task automatic cycle();
    bit     deq, ldr, alur, p1, p2;
    entry_t e;
    #1;
    if (!rst_n) q.delete();
    deq  = rst_n && (q.size() != 0) && !bus.i_wb_stall;
    ldr  = rst_n && ((q.size() < DP) || deq);
    alur = ldr && !bus.i_ld_valid;
    p1 = 1'b0;
    p2 = 1'b0;
    foreach (q[k]) begin
      if (bus.i_query_rd1 != 0 && q[k].rd == bus.i_query_rd1) p1 = 1'b1;
      if (bus.i_query_rd2 != 0 && q[k].rd == bus.i_query_rd2) p2 = 1'b1;
    end
    chk("count",     64'(bus.o_count),     64'(q.size()));
    chk("empty",     64'(bus.o_empty),     64'(q.size() == 0));
    chk("regwrite",  64'(bus.o_RegWrite),  64'(deq));
    chk("writereg",  64'(bus.o_WriteReg),  (q.size() != 0) ? 64'(q[0].rd) : 64'd0);
    chk("writedata", bus.o_WriteData,      (q.size() != 0) ? q[0].data : 64'd0);
    chk("ld_ready",  64'(bus.o_ld_ready),  64'(ldr));
    chk("alu_ready", 64'(bus.o_alu_ready), 64'(alur));
    chk("pend1",     64'(bus.o_pend1),     64'(p1));
    chk("pend2",     64'(bus.o_pend2),     64'(p2));
    if (rst_n) begin
      if (deq) void'(q.pop_front());
      if (bus.i_ld_valid && ldr) begin
        if (bus.i_ld_rd != 0) begin
          e.rd = bus.i_ld_rd; e.data = bus.i_ld_data; q.push_back(e);
        end
      end else if (bus.i_alu_valid && alur && bus.i_alu_rd != 0) begin
        e.rd = bus.i_alu_rd; e.data = bus.i_alu_data; q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    bus.i_wb_stall  = 1'b0;
    bus.i_query_rd1 = '0;
    bus.i_query_rd2 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    // ALU write into empty queue appears exactly one cycle later, then queue empties.
    alu(5'd5, 64'h1234);
    cycle();
    idle();
    #1;
    chk("s1_regwrite", 64'(bus.o_RegWrite), 64'd1);
    chk("s1_wreg",     64'(bus.o_WriteReg), 64'd5);
    chk("s1_wdata",    bus.o_WriteData,     64'h1234);
    cycle();
    #1;
    chk("s1_empty", 64'(bus.o_empty), 64'd1);
    cycle();

    // Load wins over ALU; ALU retried next cycle; write order 3 then 7.
    ld(5'd3, 64'h33);
    alu(5'd7, 64'h77);
    #1;
    chk("s2_alu_ready", 64'(bus.o_alu_ready), 64'd0);
    cycle();
    bus.i_ld_valid = 1'b0;
    #1;
    chk("s2_wreg_first", 64'(bus.o_WriteReg), 64'd3);
    cycle();
    idle();
    #1;
    chk("s2_wreg_second", 64'(bus.o_WriteReg), 64'd7);
    cycle();
    cycle();

    // Stalled: five offered, four taken; release drains 1..4 back to back.
    bus.i_wb_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      alu(5'(i), 64'(i * 16));
      if (i == 5) begin
        #1;
        chk("s3_count_full", 64'(bus.o_count),     64'd4);
        chk("s3_alu_ready",  64'(bus.o_alu_ready), 64'd0);
      end
      cycle();
    end
    idle();
    bus.i_wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("s3_drain_reg", 64'(bus.o_WriteReg), 64'(i));
      chk("s3_drain_we",  64'(bus.o_RegWrite), 64'd1);
      cycle();
    end

    // Full queue, stall released with ALU rd=9 waiting: enqueue and dequeue together.
    bus.i_wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu(5'(i + 10), 64'(i));
      cycle();
    end
    alu(5'd9, 64'h99);
    bus.i_wb_stall = 1'b0;
    #1;
    chk("s4_alu_ready", 64'(bus.o_alu_ready), 64'd1);
    cycle();
    idle();
    #1;
    chk("s4_count", 64'(bus.o_count), 64'd4);
    for (int i = 0; i < 5; i++) cycle();

    // x0 write is swallowed; pending match on a queued index; query 0 never pends.
    alu(5'd0, 64'hFFFF);
    #1;
    chk("s5_alu_ready", 64'(bus.o_alu_ready), 64'd1);
    cycle();
    idle();
    #1;
    chk("s5_count",    64'(bus.o_count),    64'd0);
    chk("s5_regwrite", 64'(bus.o_RegWrite), 64'd0);
    cycle();
    bus.i_wb_stall = 1'b1;
    alu(5'd6, 64'h66);
    cycle();
    idle();
    bus.i_query_rd1 = 5'd6;
    #1;
    chk("s5_pend_hit", 64'(bus.o_pend1), 64'd1);
    cycle();
    bus.i_query_rd1 = 5'd0;
    #1;
    chk("s5_pend_x0", 64'(bus.o_pend1), 64'd0);
    cycle();
    bus.i_wb_stall = 1'b0;
    cycle();
    cycle();

    // Reset mid-cycle with three entries queued: outputs drop at once, nothing retires.
    bus.i_wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu(5'(i + 20), 64'(i));
      cycle();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_count",    64'(bus.o_count),    64'd0);
    chk("s6_empty",    64'(bus.o_empty),    64'd1);
    chk("s6_wreg",     64'(bus.o_WriteReg), 64'd0);
    chk("s6_ld_ready", 64'(bus.o_ld_ready), 64'd0);
    cycle();
    rst_n = 1'b1;
    bus.i_wb_stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic with occasional stalls and resets.
    for (int n = 0; n < 800; n++) begin
      bus.i_ld_valid  = ($urandom_range(0, 2) == 0);
      bus.i_ld_rd     = 5'($urandom_range(0, 7));
      bus.i_ld_data   = {$urandom, $urandom};
      bus.i_alu_valid = ($urandom_range(0, 1) == 0);
      bus.i_alu_rd    = 5'($urandom_range(0, 7));
      bus.i_alu_data  = {$urandom, $urandom};
      bus.i_wb_stall  = ($urandom_range(0, 2) == 0);
      bus.i_query_rd1 = 5'($urandom_range(0, 7));
      bus.i_query_rd2 = 5'($urandom_range(0, 7));
      rst_n           = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
